alu_cmd_sequencer: RTL

- Initiator-side front end for the 4-bit team ALU.
- Accepts byte-serial two-byte commands (opcode + tag, then operands) over a valid/ready interface and drives the ALU operand/opcode ports.
- Samples the ALU result after a fixed latency and returns tagged results through a small result FIFO with valid/ready handshake.
- Sits between the chip input pins / host sequencer and the combinational ALU core.

---
 rtl/alu_cmd_sequencer_if.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Purpose: bundles the command, ALU and result-FIFO signals of alu_cmd_sequencer.
// Ports (master = sequencer side, slave = host/ALU/consumer side):
//   cmd_valid/cmd_ready/cmd_data    byte-serial command stream into the sequencer
//   alu_a/alu_b/alu_op/alu_result   operand/opcode drive and result return of the ALU
//   res_valid/res_ready/res_data/res_tag/res_count  tagged result FIFO head and occupancy
//   busy                            sequencer is not idle
interface alu_cmd_sequencer_if #(
    parameter int unsigned RES_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RES_DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_data;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_op;
    logic [7:0]       alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [4:0]       res_tag;
    logic [CNT_W-1:0] res_count;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_data, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output res_valid, res_data, res_tag, res_count, busy
    );

    modport slave (
        output cmd_valid, cmd_data, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_data, res_tag, res_count, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Purpose: initiator front end for the 4-bit ALU. Collects two-byte commands
// (byte 0 = {tag, op}, byte 1 = {b, a}), drives the ALU for ALU_LATENCY cycles,
// then captures the result with its tag into a small result FIFO.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_cmd_sequencer_if.master: command input, ALU drive/return, result FIFO, busy
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned RES_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.master bus
);
    localparam int unsigned PTR_W    = $clog2(RES_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [2:0]  LAT_LOAD = 3'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, GET_OPS, ISSUE, CAPTURE} state_e;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] tag;
    } res_entry_t;

    state_e           state_q, state_d;
    logic [2:0]       lat_q, lat_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       tag_q, tag_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic             cmd_ready_q;
    logic             busy_q;

    res_entry_t       mem_q [RES_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    res_entry_t       head_q, head_d;
    logic             res_valid_q;

    logic             xfer_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    res_entry_t       push_entry_c;

    // Handshake qualifiers; a full FIFO still accepts a push when it pops the same cycle.
    always_comb begin
        xfer_c       = bus.cmd_valid && cmd_ready_q;
        full_c       = (count_q == CNT_W'(RES_DEPTH));
        pop_c        = res_valid_q && bus.res_ready;
        push_c       = (state_q == CAPTURE) && (!full_c || pop_c);
        push_entry_c = '{data: bus.alu_result, tag: tag_q};
    end

    // Command FSM next state and operand latches.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        op_d    = op_q;
        tag_d   = tag_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    op_d    = bus.cmd_data[2:0];
                    tag_d   = bus.cmd_data[7:3];
                    state_d = GET_OPS;
                end
            end
            GET_OPS: begin
                if (xfer_c) begin
                    a_d     = bus.cmd_data[3:0];
                    b_d     = bus.cmd_data[7:4];
                    lat_d   = LAT_LOAD;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_q == 3'd0) begin
                    state_d = CAPTURE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            CAPTURE: begin
                if (push_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, occupancy and registered head. A push into the slot that
    // becomes head this cycle bypasses the memory so the head is never stale.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        head_d   = head_q;
        if (count_d != '0) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_entry_c;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cmd_ready_q <= (state_d == IDLE) || (state_d == GET_OPS);
            busy_q      <= (state_d != IDLE);
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            res_valid_q <= (count_d != '0);
        end
    end

    // Result storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wr_ptr_q] <= push_entry_c;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = head_q.data;
    assign bus.res_tag   = head_q.tag;
    assign bus.res_count = count_q;
    assign bus.busy      = busy_q;
endmodule
